param_reservation_station: RTL and testbench
============================================

Name: param_reservation_station

Overview:
- Generalised Tomasulo reservation station with DEPTH entries shared by two functional units: the add/sub ALU and the load/store unit.
- Tags are RS entry indices, not register names, so several in-flight writers of one register are legal.
- Holds an internal register-status table and captures operands from the register bank or the CDB.
- Sits between the instruction queue and the two FUs; the CDB feeds results back into it.

Parameters:
- DEPTH, 4, number of RS entries (2..16).
- DATA_W, 16, operand/result width.
- NUM_REGS, 8, architectural registers.
- TAG_W, $clog2(DEPTH), entry tag width (derived, not overridden).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- issue_valid  in  1  instruction queue presents an instruction.
- issue_ready  out  1  RS accepts it this cycle (combinational).
- issue_op  in  3  000 add, 001 sub, 010 load, 011 store.
- issue_rd/issue_rs/issue_rt  in  $clog2(NUM_REGS) each  destination register / first source / second source.
- issue_imm  in  4  load/store offset.
- regs_flat  in  NUM_REGS*DATA_W  register bank contents; register r at [r*DATA_W +: DATA_W].
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  TAG_W  producing entry.
- cdb_data  in  DATA_W  result.
- alu_valid/alu_ready  out/in  1  ALU dispatch handshake.
- alu_op  out  3  operation.
- alu_a, alu_b  out  DATA_W  operands.
- alu_tag  out  TAG_W  entry tag.
- mem_valid/mem_ready  out/in  1  load/store dispatch handshake.
- mem_op  out  3  operation.
- mem_base, mem_data  out  DATA_W  base register value / store data.
- mem_off  out  4  offset.
- mem_tag  out  TAG_W  entry tag.
- occupancy  out  TAG_W+1  number of non-FREE entries.

Behaviour:
- Reset (reset==0 at posedge):
  - All entries FREE; all register-status tags invalid.
  - alu_valid=0, mem_valid=0, occupancy=0, all data/tag outputs 0.
- Per-entry FSM:
  - FREE -> WAIT on issue.
  - WAIT -> READY when both Q fields are invalid. An issue with no pending sources enters READY directly.
  - READY -> EXEC on dispatch handshake (valid&&ready).
  - EXEC -> FREE on cdb_valid with cdb_tag == own index.
  - Store: READY -> FREE on handshake (no broadcast).
- Issue:
  - issue_ready = any entry FREE, judged on registered state. An entry freed by the CDB this cycle is not reusable until the next cycle.
  - The lowest-index FREE entry is allocated.
- Source capture at issue:
  - If the register status for the source is invalid, V = regs_flat value and Q invalid.
  - Otherwise Q = status tag.
  - Load uses rs only; rt is ignored.
  - Store uses rs (base) and rt (data).
  - Add/sub uses rs and rt.
- Destination at issue: for add/sub/load, status[rd] = allocated tag.
  - Sources read the old status, so rd==rs is correct.
  - If a CDB clear and an issue hit the same register in one cycle, issue wins.
- CDB broadcast:
  - Every WAIT entry whose Qj/Qk matches cdb_tag captures cdb_data and invalidates Q.
  - status[r] is cleared only if it still equals cdb_tag.
- Dispatch:
  - Each FU independently picks the lowest-index READY entry of its class.
  - Outputs are registered; valid is held with stable payload until ready.
  - At most one dispatch per FU per cycle.
- Width rules:
  - Add/sub results are truncated to DATA_W by the FU.
  - issue_imm is zero-extended only by the FU; mem_off carries 4 bits.
- Opcodes 1xx: issue_ready is still asserted, but the instruction is dropped with no allocation.
- Mid-operation reset: all in-flight entries are discarded. A later CDB with a stale tag matches nothing, since all Q fields are invalid.

Optional Feature:
- CDB_BYPASS_EN
  - Defined: if an issuing source's status tag equals cdb_tag while cdb_valid is high, the value comes from cdb_data and Q is invalid.
  - Undefined: issue_ready is forced 0 that cycle; the instruction issues one cycle later, reading regs_flat after writeback.

Decomposition:
- Package rs_pkg holds:
  - Opcode localparams (OP_ADD, OP_SUB, OP_LOAD, OP_STORE).
  - Entry-state enum (ST_FREE, ST_WAIT, ST_READY, ST_EXEC).
  - The entry struct typedef.
- Sub-module rs_pick_lowest (parameter N): one-hot/index priority picker, instantiated three times (free-entry allocation, ALU select, MEM select).

Test Plan:
- Reset, then issue add R1=R2+R3 with R2=5, R3=7, alu_ready=1 -> alu_valid next cycle, a=5, b=7, tag=0; cdb(tag 0, 12) -> entry FREE, occupancy 0.
- RAW dependency: add R1=R2+R3; sub R4=R1-R2 with alu_ready=0 -> second entry WAIT with Qj=0; cdb(0, 20) -> entry READY, alu_b=5 after first dispatch, a=20.
- WAW: two adds to R1 (tags 0 and 1); cdb tag 0 -> status[R1] stays 1; a later sub reading R1 waits on tag 1.
- Full: DEPTH=4 issues with FU ready=0 -> issue_ready=0 and occupancy=4; cdb frees tag 2 -> issue_ready=1 next cycle and tag 2 is reallocated.
- Bypass: issue reading R1 in the same cycle as cdb(tag of R1, 9) -> with CDB_BYPASS_EN the operand is 9 and the entry is READY; without it, issue_ready=0 that cycle.
- Store plus reset: store dispatched with mem_ready=1 -> entry FREE without CDB; reset=0 mid-flight -> all valids 0 and occupancy 0 next cycle.

Source files
------------

// File: rtl/param_reservation_station_pkg.sv
// Shared opcodes, entry-state encoding and entry record for the reservation station.
package rs_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } rs_state_e;

    // Tags and operand values are width-parameterised, so they live in arrays beside this record.
    typedef struct packed {
        rs_state_e  state;
        logic [2:0] op;
        logic [3:0] imm;
        logic       qj_v;
        logic       qk_v;
    } rs_entry_t;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/param_reservation_station_pick_lowest.sv
// Priority picker: reports whether any request is set and the index of the lowest one.
module rs_pick_lowest #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req_i[i] && !found_o) begin
                found_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/param_reservation_station.sv
// Tomasulo reservation station shared by the ALU and load/store unit, tags are entry indices.
// Optional CDB_BYPASS_EN: issuing sources may take cdb_data directly instead of stalling a cycle.
module param_reservation_station
    import rs_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    localparam int unsigned TAG_W   = $clog2(DEPTH),
    localparam int unsigned RW      = $clog2(NUM_REGS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [2:0]                 issue_op,
    input  logic [RW-1:0]              issue_rd,
    input  logic [RW-1:0]              issue_rs,
    input  logic [RW-1:0]              issue_rt,
    input  logic [3:0]                 issue_imm,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    output logic                       alu_valid,
    input  logic                       alu_ready,
    output logic [2:0]                 alu_op,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic [TAG_W-1:0]           alu_tag,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [2:0]                 mem_op,
    output logic [DATA_W-1:0]          mem_base,
    output logic [DATA_W-1:0]          mem_data,
    output logic [3:0]                 mem_off,
    output logic [TAG_W-1:0]           mem_tag,
    output logic [TAG_W:0]             occupancy
);

`ifdef CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0]   regs [NUM_REGS];
    rs_entry_t           entry_q [DEPTH], entry_d [DEPTH];
    logic [DATA_W-1:0]   vj_q [DEPTH], vj_d [DEPTH], vk_q [DEPTH], vk_d [DEPTH];
    logic [TAG_W-1:0]    qj_q [DEPTH], qj_d [DEPTH], qk_q [DEPTH], qk_d [DEPTH];
    logic [NUM_REGS-1:0] stat_v_q, stat_v_d;
    logic [TAG_W-1:0]    stat_tag_q [NUM_REGS], stat_tag_d [NUM_REGS];

    logic                alu_valid_q, alu_valid_d, mem_valid_q, mem_valid_d;
    logic [2:0]          alu_op_q, alu_op_d, mem_op_q, mem_op_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [DATA_W-1:0]   mem_base_q, mem_base_d, mem_data_q, mem_data_d;
    logic [3:0]          mem_off_q, mem_off_d;
    logic [TAG_W-1:0]    alu_tag_q, alu_tag_d, mem_tag_q, mem_tag_d;

    logic [DEPTH-1:0]    free_req, alu_req, mem_req;
    logic                free_found, alu_found, mem_found;
    logic [TAG_W-1:0]    free_idx, alu_idx, mem_idx;
    logic                uses_rt, hit_j, hit_k, stall, do_issue, qj_new, qk_new;
    logic [TAG_W:0]      occ;

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) regs[r] = regs_flat[r*DATA_W +: DATA_W];
    end

    // The entry already held in an output register stays READY until its handshake, so mask it.
    always_comb begin
        occ = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            free_req[i] = (entry_q[i].state == ST_FREE);
            alu_req[i]  = (entry_q[i].state == ST_READY) && is_alu_op(entry_q[i].op)
                          && !(alu_valid_q && alu_tag_q == TAG_W'(i));
            mem_req[i]  = (entry_q[i].state == ST_READY) && !is_alu_op(entry_q[i].op)
                          && !(mem_valid_q && mem_tag_q == TAG_W'(i));
            if (entry_q[i].state != ST_FREE) occ = occ + (TAG_W+1)'(1);
        end
    end

    rs_pick_lowest #(.N(DEPTH)) u_pick_free (.req_i(free_req), .found_o(free_found), .idx_o(free_idx));
    rs_pick_lowest #(.N(DEPTH)) u_pick_alu  (.req_i(alu_req),  .found_o(alu_found),  .idx_o(alu_idx));
    rs_pick_lowest #(.N(DEPTH)) u_pick_mem  (.req_i(mem_req),  .found_o(mem_found),  .idx_o(mem_idx));

    assign uses_rt     = !issue_op[2] && (issue_op != OP_LOAD);
    assign hit_j       = cdb_valid && stat_v_q[issue_rs] && (stat_tag_q[issue_rs] == cdb_tag);
    assign hit_k       = cdb_valid && stat_v_q[issue_rt] && (stat_tag_q[issue_rt] == cdb_tag);
    assign stall       = !BYPASS && ((!issue_op[2] && hit_j) || (uses_rt && hit_k));
    assign issue_ready = free_found && !stall;
    assign do_issue    = issue_valid && issue_ready && !issue_op[2];

    always_comb begin
        entry_d     = entry_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        stat_v_d    = stat_v_q;
        stat_tag_d  = stat_tag_q;
        alu_valid_d = alu_valid_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_tag_d   = alu_tag_q;
        mem_valid_d = mem_valid_q;
        mem_op_d    = mem_op_q;
        mem_base_d  = mem_base_q;
        mem_data_d  = mem_data_q;
        mem_off_d   = mem_off_q;
        mem_tag_d   = mem_tag_q;
        qj_new      = 1'b0;
        qk_new      = 1'b0;

        if (cdb_valid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (entry_q[i].state == ST_WAIT) begin
                    if (entry_q[i].qj_v && qj_q[i] == cdb_tag) begin
                        vj_d[i] = cdb_data;
                        entry_d[i].qj_v = 1'b0;
                    end
                    if (entry_q[i].qk_v && qk_q[i] == cdb_tag) begin
                        vk_d[i] = cdb_data;
                        entry_d[i].qk_v = 1'b0;
                    end
                end
                if (entry_q[i].state == ST_EXEC && cdb_tag == TAG_W'(i)) entry_d[i].state = ST_FREE;
            end
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (stat_v_q[r] && stat_tag_q[r] == cdb_tag) stat_v_d[r] = 1'b0;
            end
        end

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_d[i].state == ST_WAIT && !entry_d[i].qj_v && !entry_d[i].qk_v)
                entry_d[i].state = ST_READY;
        end

        if (alu_valid_q && alu_ready) begin
            entry_d[alu_tag_q].state = ST_EXEC;
            alu_valid_d = 1'b0;
        end
        if ((!alu_valid_q || alu_ready) && alu_found) begin
            alu_valid_d = 1'b1;
            alu_op_d    = entry_q[alu_idx].op;
            alu_a_d     = vj_q[alu_idx];
            alu_b_d     = vk_q[alu_idx];
            alu_tag_d   = alu_idx;
        end

        // Stores never broadcast, so they retire on the handshake itself.
        if (mem_valid_q && mem_ready) begin
            entry_d[mem_tag_q].state = (mem_op_q == OP_STORE) ? ST_FREE : ST_EXEC;
            mem_valid_d = 1'b0;
        end
        if ((!mem_valid_q || mem_ready) && mem_found) begin
            mem_valid_d = 1'b1;
            mem_op_d    = entry_q[mem_idx].op;
            mem_base_d  = vj_q[mem_idx];
            mem_data_d  = vk_q[mem_idx];
            mem_off_d   = entry_q[mem_idx].imm;
            mem_tag_d   = mem_idx;
        end

        if (do_issue) begin
            if (stat_v_q[issue_rs] && !(BYPASS && hit_j)) begin
                qj_new           = 1'b1;
                qj_d[free_idx]   = stat_tag_q[issue_rs];
                vj_d[free_idx]   = '0;
            end else begin
                vj_d[free_idx]   = hit_j ? cdb_data : regs[issue_rs];
            end
            if (!uses_rt) begin
                vk_d[free_idx]   = '0;
            end else if (stat_v_q[issue_rt] && !(BYPASS && hit_k)) begin
                qk_new           = 1'b1;
                qk_d[free_idx]   = stat_tag_q[issue_rt];
                vk_d[free_idx]   = '0;
            end else begin
                vk_d[free_idx]   = hit_k ? cdb_data : regs[issue_rt];
            end
            entry_d[free_idx].op    = issue_op;
            entry_d[free_idx].imm   = issue_imm;
            entry_d[free_idx].qj_v  = qj_new;
            entry_d[free_idx].qk_v  = qk_new;
            entry_d[free_idx].state = (qj_new || qk_new) ? ST_WAIT : ST_READY;
            // Written after the CDB clear so a same-cycle issue to the same register wins.
            if (issue_op != OP_STORE) begin
                stat_v_d[issue_rd]   = 1'b1;
                stat_tag_d[issue_rd] = free_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
            end
            for (int unsigned r = 0; r < NUM_REGS; r++) stat_tag_q[r] <= '0;
            stat_v_q    <= '0;
            alu_valid_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_tag_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_op_q    <= '0;
            mem_base_q  <= '0;
            mem_data_q  <= '0;
            mem_off_q   <= '0;
            mem_tag_q   <= '0;
        end else begin
            entry_q     <= entry_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            stat_v_q    <= stat_v_d;
            stat_tag_q  <= stat_tag_d;
            alu_valid_q <= alu_valid_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_tag_q   <= alu_tag_d;
            mem_valid_q <= mem_valid_d;
            mem_op_q    <= mem_op_d;
            mem_base_q  <= mem_base_d;
            mem_data_q  <= mem_data_d;
            mem_off_q   <= mem_off_d;
            mem_tag_q   <= mem_tag_d;
        end
    end

    assign alu_valid = alu_valid_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_tag   = alu_tag_q;
    assign mem_valid = mem_valid_q;
    assign mem_op    = mem_op_q;
    assign mem_base  = mem_base_q;
    assign mem_data  = mem_data_q;
    assign mem_off   = mem_off_q;
    assign mem_tag   = mem_tag_q;
    assign occupancy = occ;

endmodule

// File: tb/tb_param_reservation_station.sv
// Self-checking bench for param_reservation_station: vector table plus dependency/full/bypass/reset sequences.
module tb_param_reservation_station;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, LD = 3'b010, ST = 3'b011;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid, issue_ready;
    logic [2:0]  issue_op, issue_rd, issue_rs, issue_rt;
    logic [3:0]  issue_imm;
    logic [127:0] regs_flat;
    logic        cdb_valid;
    logic [1:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [2:0]  alu_op, mem_op;
    logic [15:0] alu_a, alu_b, mem_base, mem_data;
    logic [3:0]  mem_off;
    logic [1:0]  alu_tag, mem_tag;
    logic [2:0]  occupancy;

    logic [15:0] regs [8];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  off;
        logic [1:0]  tag;
    } exp_t;
    exp_t alu_q[$];
    exp_t mem_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd, rs, rt;
        logic [3:0]  imm;
        logic [15:0] rsv, rtv;
        logic        is_mem, dropped;
        logic [15:0] e_a, e_b;
        logic [3:0]  e_off;
        logic [2:0]  e_occ;
    } vec_t;
    vec_t vec [7];

    always #5 clock = ~clock;

    always_comb begin
        for (int r = 0; r < 8; r++) regs_flat[r*16 +: 16] = regs[r];
    end

    param_reservation_station #(.DEPTH(4), .DATA_W(16), .NUM_REGS(8)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_imm(issue_imm),
        .regs_flat(regs_flat),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_tag(alu_tag),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_op(mem_op),
        .mem_base(mem_base), .mem_data(mem_data), .mem_off(mem_off), .mem_tag(mem_tag),
        .occupancy(occupancy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare each handshaken dispatch against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset && alu_valid && alu_ready) begin
            if (alu_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL alu_unexpected: got dispatch tag %0d a=0x%0h expected none", alu_tag, alu_a);
            end else begin
                e = alu_q.pop_front();
                check("alu_op", alu_op, e.op);
                check("alu_a", alu_a, e.a);
                check("alu_b", alu_b, e.b);
                check("alu_tag", alu_tag, e.tag);
            end
        end
        if (reset && mem_valid && mem_ready) begin
            if (mem_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL mem_unexpected: got dispatch tag %0d expected none", mem_tag);
            end else begin
                e = mem_q.pop_front();
                check("mem_op", mem_op, e.op);
                check("mem_base", mem_base, e.a);
                check("mem_data", mem_data, e.b);
                check("mem_off", mem_off, e.off);
                check("mem_tag", mem_tag, e.tag);
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic push_alu(input logic [2:0] op, input logic [15:0] a, b, input logic [1:0] tag);
        alu_q.push_back('{op: op, a: a, b: b, off: 4'd0, tag: tag});
    endtask

    task automatic push_mem(input logic [2:0] op, input logic [15:0] a, b, input logic [3:0] off,
                            input logic [1:0] tag);
        mem_q.push_back('{op: op, a: a, b: b, off: off, tag: tag});
    endtask

    task automatic do_reset();
        reset = 1'b0; issue_valid = 1'b0; cdb_valid = 1'b0;
        alu_ready = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic do_issue(input logic [2:0] op, rd, rs, rt, input logic [3:0] imm, input string name);
        int k = 0;
        issue_valid = 1'b1; issue_op = op; issue_rd = rd; issue_rs = rs; issue_rt = rt; issue_imm = imm;
        #1;
        while (!issue_ready && k < 20) begin
            @(posedge clock); #2; k++;
        end
        if (!issue_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_issue_timeout: got issue_ready=0 expected 1 within 20 cycles", name);
        end
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic cdb(input logic [1:0] tag, input logic [15:0] data);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((alu_q.size() != 0 || mem_q.size() != 0) && k < 30) begin
            tick(); k++;
        end
        if (alu_q.size() != 0 || mem_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_drain: got %0d alu + %0d mem pending expected 0", name, alu_q.size(), mem_q.size());
            alu_q.delete(); mem_q.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 8; r++) regs[r] = 16'h0;
        issue_op = '0; issue_rd = '0; issue_rs = '0; issue_rt = '0; issue_imm = '0;
        cdb_tag = '0; cdb_data = '0;

        //            op     rd    rs    rt    imm    rsv       rtv       mem   drop  e_a       e_b       off    occ
        vec[0] = '{ADD,    3'd1, 3'd2, 3'd3, 4'h0, 16'h0005, 16'h0007, 1'b0, 1'b0, 16'h0005, 16'h0007, 4'h0, 3'd1};
        vec[1] = '{SUB,    3'd4, 3'd5, 3'd6, 4'h0, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 16'h0003, 16'hFFFF, 4'h0, 3'd1};
        vec[2] = '{ADD,    3'd7, 3'd7, 3'd0, 4'h0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 4'h0, 3'd1};
        vec[3] = '{LD,     3'd2, 3'd3, 3'd4, 4'hF, 16'h1234, 16'h5555, 1'b1, 1'b0, 16'h1234, 16'h0000, 4'hF, 3'd1};
        vec[4] = '{ST,     3'd0, 3'd6, 3'd1, 4'h0, 16'h8000, 16'h00FF, 1'b1, 1'b0, 16'h8000, 16'h00FF, 4'h0, 3'd0};
        vec[5] = '{3'b100, 3'd1, 3'd2, 3'd3, 4'h1, 16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'h0, 3'd0};
        vec[6] = '{3'b111, 3'd5, 3'd6, 3'd7, 4'h2, 16'h0003, 16'h0004, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'h0, 3'd0};

        // Reset state
        do_reset();
        check("rst_alu_valid", alu_valid, 1'b0);
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_occupancy", occupancy, 3'd0);
        check("rst_alu_a", alu_a, 16'h0);
        check("rst_mem_base", mem_base, 16'h0);
        check("rst_issue_ready", issue_ready, 1'b1);

        // Vector table: each instruction independent, retired before the next
        alu_ready = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            regs[vec[i].rs] = vec[i].rsv;
            regs[vec[i].rt] = vec[i].rtv;
            if (!vec[i].dropped) begin
                if (vec[i].is_mem) push_mem(vec[i].op, vec[i].e_a, vec[i].e_b, vec[i].e_off, 2'd0);
                else               push_alu(vec[i].op, vec[i].e_a, vec[i].e_b, 2'd0);
            end
            do_issue(vec[i].op, vec[i].rd, vec[i].rs, vec[i].rt, vec[i].imm, $sformatf("v%0d", i));
            wait_drain($sformatf("v%0d", i));
            tick();
            check($sformatf("v%0d_occ_exec", i), occupancy, vec[i].e_occ);
            if (!vec[i].dropped && vec[i].op != ST) cdb(2'd0, 16'h0);
            tick();
            check($sformatf("v%0d_occ_done", i), occupancy, 3'd0);
        end

        // Basic add: dispatch the cycle after issue, then CDB frees the entry
        do_reset();
        regs[2] = 16'd5; regs[3] = 16'd7; alu_ready = 1'b1;
        push_alu(ADD, 16'd5, 16'd7, 2'd0);
        do_issue(ADD, 3'd1, 3'd2, 3'd3, 4'h0, "t1");
        tick();
        check("t1_alu_valid_next", alu_valid, 1'b1);
        wait_drain("t1");
        cdb(2'd0, 16'd12);
        check("t1_occ_after_cdb", occupancy, 3'd0);
        check("t1_alu_valid_idle", alu_valid, 1'b0);

        // RAW: sub waits on tag 0 and captures the broadcast value
        do_reset();
        regs[2] = 16'd5; regs[3] = 16'd15;
        push_alu(ADD, 16'd5, 16'd15, 2'd0);
        do_issue(ADD, 3'd1, 3'd2, 3'd3, 4'h0, "raw_add");
        do_issue(SUB, 3'd4, 3'd1, 3'd2, 4'h0, "raw_sub");
        check("raw_occ", occupancy, 3'd2);
        check("raw_held_valid", alu_valid, 1'b1);
        check("raw_held_tag", alu_tag, 2'd0);
        alu_ready = 1'b1;
        wait_drain("raw_add");
        repeat (3) tick();
        push_alu(SUB, 16'd20, 16'd5, 2'd1);
        cdb(2'd0, 16'd20);
        wait_drain("raw_sub");
        cdb(2'd1, 16'd15);
        check("raw_occ_end", occupancy, 3'd0);

        // WAW: stale broadcast must not clear the newer status of R1
        do_reset();
        regs[1] = 16'd0; regs[2] = 16'd1; regs[3] = 16'd2; regs[5] = 16'd3;
        alu_ready = 1'b1;
        push_alu(ADD, 16'd1, 16'd2, 2'd0);
        push_alu(ADD, 16'd3, 16'd2, 2'd1);
        do_issue(ADD, 3'd1, 3'd2, 3'd3, 4'h0, "waw_a0");
        do_issue(ADD, 3'd1, 3'd5, 3'd3, 4'h0, "waw_a1");
        wait_drain("waw_adds");
        cdb(2'd0, 16'd3);
        do_issue(SUB, 3'd4, 3'd1, 3'd2, 4'h0, "waw_sub");
        repeat (3) tick();
        check("waw_occ", occupancy, 3'd2);
        push_alu(SUB, 16'd5, 16'd1, 2'd0);
        cdb(2'd1, 16'd5);
        wait_drain("waw_sub");
        cdb(2'd0, 16'd4);
        check("waw_occ_end", occupancy, 3'd0);

        // Full: four entries, CDB frees tag 2 which becomes allocatable one cycle later
        do_reset();
        regs[6] = 16'd6; regs[7] = 16'd7;
        for (int i = 0; i < 4; i++) begin
            push_alu(ADD, 16'd6, 16'd7, 2'(i));
            do_issue(ADD, 3'(i + 1), 3'd6, 3'd7, 4'h0, $sformatf("full%0d", i));
        end
        check("full_occ", occupancy, 3'd4);
        check("full_issue_ready", issue_ready, 1'b0);
        alu_ready = 1'b1;
        wait_drain("full");
        cdb_valid = 1'b1; cdb_tag = 2'd2; cdb_data = 16'd13;
        #1;
        check("full_ready_cdb_cycle", issue_ready, 1'b0);
        @(posedge clock); #1;
        cdb_valid = 1'b0;
        check("full_ready_after", issue_ready, 1'b1);
        check("full_occ_after", occupancy, 3'd3);
        push_alu(ADD, 16'd6, 16'd7, 2'd2);
        do_issue(ADD, 3'd5, 3'd6, 3'd7, 4'h0, "full_realloc");
        wait_drain("full_realloc");
        cdb(2'd0, 16'd13); cdb(2'd1, 16'd13); cdb(2'd3, 16'd13); cdb(2'd2, 16'd13);
        check("full_occ_end", occupancy, 3'd0);

        // Bypass: issue reads R1 in the same cycle its producer broadcasts
        do_reset();
        regs[1] = 16'd0; regs[2] = 16'd5; regs[3] = 16'd7; alu_ready = 1'b1;
        push_alu(ADD, 16'd5, 16'd7, 2'd0);
        do_issue(ADD, 3'd1, 3'd2, 3'd3, 4'h0, "byp_add");
        wait_drain("byp_add");
        regs[1] = 16'd9;
        cdb_valid = 1'b1; cdb_tag = 2'd0; cdb_data = 16'd9;
        issue_valid = 1'b1; issue_op = SUB; issue_rd = 3'd4; issue_rs = 3'd1; issue_rt = 3'd2;
        #1;
`ifdef CDB_BYPASS_EN
        check("byp_issue_ready", issue_ready, 1'b1);
        push_alu(SUB, 16'd9, 16'd5, 2'd1);
        @(posedge clock); #1;
        cdb_valid = 1'b0; issue_valid = 1'b0;
        wait_drain("byp_sub");
        cdb(2'd1, 16'd4);
`else
        check("byp_issue_stall", issue_ready, 1'b0);
        push_alu(SUB, 16'd9, 16'd5, 2'd0);
        @(posedge clock); #1;
        cdb_valid = 1'b0;
        #1;
        check("byp_issue_ready_next", issue_ready, 1'b1);
        @(posedge clock); #1;
        issue_valid = 1'b0;
        wait_drain("byp_sub");
        cdb(2'd0, 16'd4);
`endif
        check("byp_occ_end", occupancy, 3'd0);

        // Store retires on handshake; reset mid-flight discards everything
        do_reset();
        regs[1] = 16'h0011; regs[2] = 16'h0100; regs[3] = 16'hABCD; mem_ready = 1'b1;
        push_mem(ST, 16'h0100, 16'hABCD, 4'h4, 2'd0);
        do_issue(ST, 3'd0, 3'd2, 3'd3, 4'h4, "st");
        wait_drain("st");
        tick();
        check("st_occ_no_cdb", occupancy, 3'd0);
        mem_ready = 1'b0;
        do_issue(ADD, 3'd1, 3'd2, 3'd3, 4'h0, "mid_add");
        do_issue(LD, 3'd5, 3'd2, 3'd0, 4'h2, "mid_ld");
        tick();
        check("mid_alu_valid", alu_valid, 1'b1);
        check("mid_mem_valid", mem_valid, 1'b1);
        check("mid_occ", occupancy, 3'd2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_alu_valid", alu_valid, 1'b0);
        check("mid_rst_mem_valid", mem_valid, 1'b0);
        check("mid_rst_occ", occupancy, 3'd0);
        check("mid_rst_mem_base", mem_base, 16'h0);
        cdb(2'd1, 16'd77);
        check("stale_cdb_occ", occupancy, 3'd0);
        alu_ready = 1'b1;
        push_alu(SUB, 16'h0011, 16'h0100, 2'd0);
        do_issue(SUB, 3'd4, 3'd1, 3'd2, 4'h0, "post_rst");
        wait_drain("post_rst");
        check("post_rst_mem_valid", mem_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
